// File: rtl/cache_def.sv
// cache_def: shared types for the cache/memory subsystem.
//   cache_data_type : one 256-bit cache line
//   mem_req_type    : request to a line memory (addr, data, rw=1 write, valid)
//   mem_data_type   : response from a line memory (data line, ready)
//   arb_state_type  : mem_arbiter sequencer states
//   arb_id_type     : requester id (0 = D-cache, 1 = I-cache)
package cache_def;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef logic [LINE_W-1:0] cache_data_type;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        cache_data_type    data;
        logic              rw;
        logic              valid;
    } mem_req_type;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_type;

    typedef logic arb_id_type;

    localparam arb_id_type ARB_ID_DCACHE = 1'b0;
    localparam arb_id_type ARB_ID_ICACHE = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant picker for the two memory requesters.
//   valid0      in  D-cache request valid
//   valid1      in  I-cache request valid
//   last_grant  in  id granted most recently (round-robin build only)
//   grant_valid out at least one requester is asking
//   grant_id    out id of the requester that wins this cycle
// Build option MEM_ARB_RR_EN: when defined, ties go to the requester that
// was not granted last; otherwise the D-cache always wins ties.
module mem_arb_pick
    import cache_def::*;
(
    input  logic       valid0,
    input  logic       valid1,
`ifdef MEM_ARB_RR_EN
    input  arb_id_type last_grant,
`endif
    output logic       grant_valid,
    output arb_id_type grant_id
);

    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = ARB_ID_DCACHE;
        if (valid0 && valid1) begin
`ifdef MEM_ARB_RR_EN
            grant_id = ~last_grant;
`else
            grant_id = ARB_ID_DCACHE;
`endif
        end else if (valid1) begin
            grant_id = ARB_ID_ICACHE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported line memory between the D-cache
// (requester 0) and the I-cache (requester 1), one transaction at a time.
// The winning request is latched and presented to the memory for as long as
// the memory holds ready low; the returned line is then handed back to the
// owner as a one-cycle ready pulse.
//   clk      in  clock, all state on posedge
//   rst_n    in  synchronous reset, active-low
//   req0     in  D-cache request
//   resp0    out D-cache response (line + ready pulse)
//   req1     in  I-cache request
//   resp1    out I-cache response
//   mem_req  out request to the line memory
//   mem_resp in  line memory read data and ready
// Build option MEM_ARB_RR_EN: round-robin tie break with a last-grant
// register (reset value = I-cache, so the D-cache wins the first tie).
// Without it, fixed priority to the D-cache and no last-grant register.
//
// state | meaning
// IDLE  | arbitrate; latch winner's addr/data/rw/owner on a grant
// ISSUE | drive latched request to mem until mem_resp.ready
// RESP  | one-cycle ready pulse with captured line to the owner
module mem_arbiter
    import cache_def::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  mem_req_type  req0,
    output mem_data_type resp0,
    input  mem_req_type  req1,
    output mem_data_type resp1,
    output mem_req_type  mem_req,
    input  mem_data_type mem_resp
);

    arb_state_type     state_q;
    arb_state_type     state_d;
    arb_id_type        owner_q;
    logic [ADDR_W-1:0] addr_q;
    cache_data_type    wdata_q;
    logic              rw_q;
    cache_data_type    line_q;

    logic              grant_valid;
    arb_id_type        grant_id;
    logic              grant_load;
    logic              line_load;

`ifdef MEM_ARB_RR_EN
    arb_id_type        last_q;
`endif

    mem_arb_pick u_pick (
        .valid0      (req0.valid),
        .valid1      (req1.valid),
`ifdef MEM_ARB_RR_EN
        .last_grant  (last_q),
`endif
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Requests are only looked at in IDLE; requesters hold them until ready.
    assign grant_load = (state_q == IDLE) && grant_valid;
    assign line_load  = (state_q == ISSUE) && mem_resp.ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q <= ARB_ID_DCACHE;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
        end else if (grant_load) begin
            owner_q <= grant_id;
            if (grant_id == ARB_ID_ICACHE) begin
                addr_q  <= req1.addr;
                wdata_q <= req1.data;
                rw_q    <= req1.rw;
            end else begin
                addr_q  <= req0.addr;
                wdata_q <= req0.data;
                rw_q    <= req0.rw;
            end
        end
    end

    // For a write held over not-ready cycles the memory has already taken
    // the new line, so the captured line reflects it; that is intended.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_q <= '0;
        end else if (line_load) begin
            line_q <= mem_resp.data;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= ARB_ID_ICACHE;
        end else if (grant_load) begin
            last_q <= grant_id;
        end
    end
`endif

    // The memory writes on every edge that sees rw=1, so rw and valid are
    // only ever raised in ISSUE; addr/data keep their latched values so the
    // memory inputs do not toggle between transactions.
    always_comb begin
        state_d      = state_q;
        mem_req      = '0;
        mem_req.addr = addr_q;
        mem_req.data = wdata_q;
        resp0        = '0;
        resp1        = '0;
        resp0.data   = line_q;
        resp1.data   = line_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_req.valid = 1'b1;
                mem_req.rw    = rw_q;
                if (mem_resp.ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q == ARB_ID_ICACHE) begin
                    resp1.ready = 1'b1;
                end else begin
                    resp0.ready = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
    import cache_def::*;

    localparam logic [255:0] Z   = 256'h0;
    localparam logic [255:0] P1  = {8{32'h1111_1111}};
    localparam logic [255:0] P2  = {8{32'h2222_2222}};
    localparam logic [255:0] P3  = {8{32'h3333_3333}};
    localparam logic [255:0] P4  = {8{32'h4444_4444}};
    localparam logic [255:0] A5  = {32{8'hA5}};
    localparam logic [255:0] W12 = 256'h1234;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    mem_req_type  req0, req1, mem_req;
    mem_data_type resp0, resp1, mem_resp;
    logic         mem_rdy = 1'b1;
    logic         mem_clr = 1'b1;
    logic [255:0] mem_arr [16];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .resp0    (resp0),
        .req1     (req1),
        .resp1    (resp1),
        .mem_req  (mem_req),
        .mem_resp (mem_resp)
    );

    // Line memory: writes on every edge with rw=1, combinational read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
        end else if (mem_req.rw) begin
            mem_arr[mem_req.addr[14:11]] <= mem_req.data;
        end
    end
    assign mem_resp = '{data: mem_arr[mem_req.addr[14:11]], ready: mem_rdy};

    typedef struct {
        bit           v0, v1, rw0, rw1;
        logic [31:0]  a0, a1;
        logic [255:0] d0, d1;
        bit           id_rr, id_fx;
        logic [255:0] line_rr, line_fx;
    } vec_t;
    vec_t tv [7];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    function automatic mem_req_type mk(input logic rw, input logic [31:0] a, input logic [255:0] d);
        mk = '{addr: a, data: d, rw: rw, valid: 1'b1};
    endfunction

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int port, input int budget, output int cycles, output logic [255:0] line);
        cycles = -1;
        line   = '0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            samp();
            if ((port == 0) ? resp0.ready : resp1.ready) begin
                cycles = i;
                line   = (port == 0) ? resp0.data : resp1.data;
                break;
            end
        end
        if (cycles < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_ready port %0d: no ready within %0d cycles", port, budget);
        end
    endtask

    // random-phase state
    bit           act [2];
    bit           done_n [2];
    int           gap [2];
    logic [31:0]  ra [2];
    logic [255:0] rd [2];
    bit           rrw [2];
    logic [255:0] gold [16];
    bit           busy, owner, m_last, exp_v;
    int           issue_from, resp_at, free_at;
    logic [255:0] exp_line;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc_n;
        int           n;
        bit           want_id;
        logic [255:0] want_line;
        logic [255:0] line;

        tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1800, 32'h1800, P1, Z,  1'b0, 1'b0, Z,  Z};
        tv[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 32'h1800, Z,  Z,  1'b1, 1'b0, P1, Z};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,    32'h2000, Z,  P2, 1'b1, 1'b1, Z,  Z};
        tv[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 32'h1800, Z,  Z,  1'b0, 1'b0, P2, P2};
        tv[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h2800, 32'h0,    P3, Z,  1'b0, 1'b0, Z,  Z};
        tv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h2800, 32'h2000, Z,  Z,  1'b1, 1'b0, P2, P3};
        tv[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h2800, Z,  Z,  1'b1, 1'b1, P3, P3};

        // reset with both requesters asking
        req0 = mk(1'b1, 32'h800, '1);
        req1 = mk(1'b1, 32'h1000, '1);
        for (int i = 0; i < 2; i++) begin
            tick();
            samp();
            chk("rst rw", mem_req.rw, 0);
            chk("rst valid", mem_req.valid, 0);
            chk("rst ready0", resp0.ready, 0);
            chk("rst ready1", resp1.ready, 0);
            chk("rst data0", resp0.data, Z);
            chk("rst addr", mem_req.addr, 0);
        end
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        req0    = '0;
        req1    = '0;

        // single-transaction vectors from IDLE
        for (int i = 0; i < 7; i++) begin
            tick();
            req0 = tv[i].v0 ? mk(tv[i].rw0, tv[i].a0, tv[i].d0) : '0;
            req1 = tv[i].v1 ? mk(tv[i].rw1, tv[i].a1, tv[i].d1) : '0;
`ifdef MEM_ARB_RR_EN
            want_id   = tv[i].id_rr;
            want_line = tv[i].line_rr;
`else
            want_id   = tv[i].id_fx;
            want_line = tv[i].line_fx;
`endif
            samp();
            chk($sformatf("tv%0d idle valid", i), mem_req.valid, 0);
            tick();
            samp();
            chk($sformatf("tv%0d issue valid", i), mem_req.valid, 1);
            chk($sformatf("tv%0d issue rw", i), mem_req.rw, want_id ? tv[i].rw1 : tv[i].rw0);
            chk($sformatf("tv%0d issue addr", i), mem_req.addr, want_id ? tv[i].a1 : tv[i].a0);
            tick();
            samp();
            chk($sformatf("tv%0d ready0", i), resp0.ready, !want_id);
            chk($sformatf("tv%0d ready1", i), resp1.ready, want_id);
            chk($sformatf("tv%0d line", i), want_id ? resp1.data : resp0.data, want_line);
            chk($sformatf("tv%0d resp rw", i), mem_req.rw, 0);
            tick();
            req0 = '0;
            req1 = '0;
            samp();
            chk($sformatf("tv%0d after ready0", i), resp0.ready, 0);
            chk($sformatf("tv%0d after ready1", i), resp1.ready, 0);
            chk($sformatf("tv%0d after valid", i), mem_req.valid, 0);
        end

        // D-cache write then I-cache read of the same line
        tick();
        req0 = mk(1'b1, 32'h0000_0800, A5);
        samp();
        chk("B rw N", mem_req.rw, 0);
        tick();
        samp();
        chk("B rw N+1", mem_req.rw, 1);
        chk("B ready0 N+1", resp0.ready, 0);
        tick();
        samp();
        chk("B rw N+2", mem_req.rw, 0);
        chk("B ready0 N+2", resp0.ready, 1);
        chk("B ready1 N+2", resp1.ready, 0);
        tick();
        req0 = '0;
        req1 = mk(1'b0, 32'h0000_0800, Z);
        samp();
        chk("B rw N+3", mem_req.rw, 0);
        wait_ready(1, 8, n, line);
        chk("B read latency", n, 2);
        chk("B read line", line, A5);
        tick();
        req1 = '0;

        // both asking every cycle, six transactions
        do_reset();
        req0 = mk(1'b0, 32'h0800, Z);
        req1 = mk(1'b0, 32'h1800, Z);
        for (int t = 0; t < 6; t++) begin
            n = 0;
            for (int i = 1; i <= 10; i++) begin
                tick();
                samp();
                if (resp0.ready || resp1.ready) begin
                    n = i;
                    break;
                end
            end
`ifdef MEM_ARB_RR_EN
            want_id = bit'(t % 2);
`else
            want_id = 1'b0;
`endif
            chk($sformatf("C%0d gap", t), n, (t == 0) ? 2 : 3);
            chk($sformatf("C%0d ready0", t), resp0.ready, !want_id);
            chk($sformatf("C%0d ready1", t), resp1.ready, want_id);
            chk($sformatf("C%0d line", t), want_id ? resp1.data : resp0.data, want_id ? P1 : A5);
        end
        tick();
        req0 = '0;
        req1 = '0;

        // write held in ISSUE over three not-ready cycles
        tick();
        req1    = mk(1'b1, 32'h3000, P4);
        mem_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            mem_rdy = (i == 4);
            samp();
            chk($sformatf("D%0d valid", i), mem_req.valid, 1);
            chk($sformatf("D%0d rw", i), mem_req.rw, 1);
            chk($sformatf("D%0d ready1", i), resp1.ready, 0);
        end
        tick();
        samp();
        chk("D N+5 ready1", resp1.ready, 1);
        chk("D N+5 line", resp1.data, P4);
        chk("D N+5 rw", mem_req.rw, 0);
        tick();
        req1 = '0;

        // reset while a write sits in ISSUE
        do_reset();
        req0 = mk(1'b1, 32'h0000_1000, W12);
        tick();
        samp();
        chk("E issue rw", mem_req.rw, 1);
        rst_n = 1'b0;
        req0  = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            samp();
            chk("E rst rw", mem_req.rw, 0);
            chk("E rst valid", mem_req.valid, 0);
            chk("E rst ready0", resp0.ready, 0);
        end
        rst_n = 1'b1;
        tick();
        samp();
        chk("E post ready0", resp0.ready, 0);
        req1 = mk(1'b0, 32'h0000_1000, Z);
        wait_ready(1, 8, n, line);
        chk("E readback", line, W12);
        chk("E readback ready0", resp0.ready, 0);
        tick();
        req1 = '0;

        // randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 16; i++) gold[i] = '0;
        for (int k = 0; k < 2; k++) begin
            act[k]    = 1'b0;
            done_n[k] = 1'b0;
            gap[k]    = 0;
        end
        busy   = 1'b0;
        owner  = 1'b0;
        m_last = 1'b1;
        issue_from = 0;
        resp_at    = -1;
        free_at    = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (busy && cyc == free_at) busy = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (done_n[k]) begin
                    act[k]    = 1'b0;
                    done_n[k] = 1'b0;
                    gap[k]    = int'($urandom_range(0, 2));
                end
                if (!act[k]) begin
                    if (gap[k] == 0 && cyc < 500) begin
                        act[k] = 1'b1;
                        ra[k]  = 32'($urandom_range(8, 11)) << 11;
                        rrw[k] = bit'($urandom_range(0, 1));
                        rd[k]  = {8{$urandom}};
                    end else if (gap[k] > 0) begin
                        gap[k]--;
                    end
                end
            end
            req0    = act[0] ? mk(rrw[0], ra[0], rd[0]) : '0;
            req1    = act[1] ? mk(rrw[1], ra[1], rd[1]) : '0;
            mem_rdy = ($urandom_range(0, 3) != 0);
            if (!busy && (act[0] || act[1])) begin
                if (act[0] && act[1]) begin
`ifdef MEM_ARB_RR_EN
                    owner = !m_last;
`else
                    owner = 1'b0;
`endif
                end else begin
                    owner = act[1];
                end
                m_last     = owner;
                busy       = 1'b1;
                issue_from = cyc + 1;
                resp_at    = -1;
                free_at    = -1;
            end
            if (busy && resp_at < 0 && cyc >= issue_from && mem_rdy) begin
                exp_line = (rrw[owner] && cyc > issue_from) ? rd[owner] : gold[ra[owner][14:11]];
                if (rrw[owner]) gold[ra[owner][14:11]] = rd[owner];
                resp_at = cyc + 1;
                free_at = cyc + 2;
            end
            samp();
            exp_v = busy && cyc >= issue_from && (resp_at < 0 || cyc < resp_at);
            chk("rnd valid", mem_req.valid, exp_v);
            chk("rnd rw", mem_req.rw, exp_v && rrw[owner]);
            if (exp_v) chk("rnd addr", mem_req.addr, ra[owner]);
            chk("rnd ready0", resp0.ready, busy && cyc == resp_at && !owner);
            chk("rnd ready1", resp1.ready, busy && cyc == resp_at && owner);
            if (busy && cyc == resp_at) begin
                chk("rnd line", owner ? resp1.data : resp0.data, exp_line);
                done_n[owner] = 1'b1;
            end
        end
        chk("rnd drained", busy, 0);
        cyc_n = n_vec;

        $display("== %0d vectors applied, %0d miscompares ==", cyc_n, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer in front of the single-ported line memory `mem`. It shares the memory between the D-cache (requester 0) and the I-cache (requester 1), admitting one transaction at a time. The winner's request is latched and presented to `mem` as a well-formed one-transaction write or read. Each requester's response is returned as a one-cycle ready pulse carrying the 256-bit line.

## Interface
Parameters:
- none; widths come from `cache_def` (`mem_req_type`, `mem_data_type`, `cache_data_type`).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  synchronous reset, active-low.
- `req0`  in  `mem_req_type`  D-cache request (`addr`, `data`, `rw`=1 write, `valid`).
- `resp0`  out  `mem_data_type`  D-cache response (`data` line, `ready` pulse).
- `req1`  in  `mem_req_type`  I-cache request.
- `resp1`  out  `mem_data_type`  I-cache response.
- `mem_req`  out  `mem_req_type`  request driven to `mem`.
- `mem_resp`  in  `mem_data_type`  `mem` read data and ready.

## Operation
- FSM states and transitions:
  - IDLE: arbitrate among valid requests. On a grant, latch the winner's `addr`, `data`, `rw` and owner id, then go to ISSUE. No valid request: stay in IDLE.
  - ISSUE: drive the latched request on `mem_req` with `valid`=1 and `rw` as latched. Stay while `mem_resp.ready`=0. When `mem_resp.ready`=1, capture `mem_resp.data` into the response register and go to RESP.
  - RESP: drive the owner's `ready`=1 and `data`=captured line. The other requester sees `ready`=0. Go to IDLE.
- `mem` writes on every edge where `rw`=1, so `mem_req.rw` is 1 only in ISSUE.
  - Outside ISSUE: `rw`=0 and `valid`=0; `addr`/`data` hold their last latched values.
  - A write held in ISSUE over several not-ready cycles rewrites the same line each edge. This is idempotent and allowed.
- Write responses also pulse `ready`. The `data` returned is the line read at `addr` during ISSUE.
- `addr` passes through unmodified; `mem` indexes `addr[31:11]`.
- Requesters hold `valid` and their fields stable until they see `ready`, and drop `valid` on that edge. Requests are only sampled in IDLE.
- A requester not granted waits in IDLE arbitration with no timeout.
- Reset values:
  - state IDLE; `mem_req` all zero.
  - `resp0`/`resp1` `ready`=0, `data`=0.
  - last-grant register = 1.
- Reset mid-operation:
  - the pending transaction is dropped and no response is issued.
  - a write in ISSUE on the reset edge still lands in `mem`, because `mem` samples `rw`=1 at that edge.
  - `rw` is 0 from the next cycle.

## Timing
- Request valid in IDLE cycle N → ISSUE in N+1 → `ready` pulse in N+2 when `mem_resp.ready`=1 (the `mem` default). Minimum 3-cycle occupancy per transaction.
- Each cycle `mem_resp.ready`=0 in ISSUE adds one cycle.
- Back-to-back: the next grant is sampled in the IDLE cycle N+3, giving one transaction per 3 cycles at best.
- Simultaneous valid in IDLE: resolved per Configuration. A write to the same address by the other requester is ordered by grant order.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a tie, the requester not granted last wins. The last-grant register updates on every grant; its reset value 1 makes `req0` win the first tie.
- Not defined: fixed priority, `req0` always wins ties. The last-grant register is not built. An always-valid `req0` starves `req1`; this is accepted.

## Structure
- Add to `cache_def`:
  - `arb_state_type` enum (IDLE, ISSUE, RESP).
  - `arb_id_type` (1 bit, 0=D-cache, 1=I-cache).
- Sub-module `mem_arb_pick`: combinational grant picker. Inputs: two valids, last grant. Outputs: grant valid and id. It contains the `MEM_ARB_RR_EN` selection.
- `mem_arbiter` holds the FSM, latches, response register and output muxing.

## Test plan
- Reset with both valids high and `rst_n`=0 for 2 cycles → `mem_req.rw`=0, `valid`=0, both `ready`=0 throughout.
- `req0` write, addr 0x0000_0800, data 0xA5…A5 → `rw`=1 exactly one cycle; `resp0.ready` in N+2. A following `req1` read of 0x0000_0800 returns 0xA5…A5 on `resp1`.
- Both valid every cycle, 6 transactions:
  - RR build: grants 0,1,0,1,0,1.
  - Fixed build: all 0.
  - Each pulse lands on the correct port only.
- Force `mem_resp.ready`=0 for 3 ISSUE cycles → FSM stays in ISSUE and `ready` is delayed to N+5. The read line equals the data captured at the ready edge.
- Assert reset during ISSUE of a write of 0x1234 to 0x0000_1000 → no `resp0.ready`. The line at 0x0000_1000 reads back 0x1234 after reset.
